// File: rtl/game_round_ctrl.sv
// -----------------------------------------------------------------------------
// game_round_ctrl
//   Round/score controller for a two-tank game. The controller samples the
//   sprite-overlap hits from both tank blocks and turns them into scores. It
//   freezes both tanks for a hold period after each hit. It ends the game when
//   a player reaches WIN_SCORE. All game actions happen on the Clk cycle that
//   follows a rising edge of frame_clk.
//
//   Optional feature: define ROUND_TIMER_EN to build a per-round time limit of
//   ROUND_FRAMES frames. When the limit expires the round goes to HOLD with no
//   score change. Without the macro, timed_out is tied low.
//
// Ports
//   Clk, Reset            system clock, synchronous active-high reset
//   frame_clk             ~60 Hz frame strobe (rising edge detected here)
//   keycode[7:0]          current key; START_KEY starts/restarts a game
//   is_tank0/1            per-pixel tank sprite hits
//   is_bullet0/1          per-pixel bullet sprite hits
//   can_move              both tanks may move (PLAY only)
//   tank_rst              one-Clk pulse: tanks back to start positions
//   bullet_kill0/1        one-Clk pulse: clear that player's bullet
//   score0/1[3:0]         player scores (saturating)
//   winner[1:0]           00 none, 01 P0, 10 P1, 11 draw
//   state[1:0]            00 IDLE, 01 PLAY, 10 HOLD, 11 OVER
//   timed_out             in HOLD because the round timer expired
// -----------------------------------------------------------------------------
module game_round_ctrl #(
    parameter logic [3:0]  WIN_SCORE    = 4'd5,
    parameter logic [7:0]  HOLD_FRAMES  = 8'd60,
    parameter logic [7:0]  START_KEY    = 8'h29,
    parameter logic [10:0] ROUND_FRAMES = 11'd1800
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       is_tank0,
    input  logic       is_bullet0,
    input  logic       is_tank1,
    input  logic       is_bullet1,
    output logic       can_move,
    output logic       tank_rst,
    output logic       bullet_kill0,
    output logic       bullet_kill1,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [1:0] winner,
    output logic [1:0] state,
    output logic       timed_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_HOLD = 2'b10,
        S_OVER = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic       frame_dly_q, frame_dly_d;
    logic       fe_q, fe_d;
    logic       hit0_acc_q, hit0_acc_d;
    logic       hit1_acc_q, hit1_acc_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       can_move_q, can_move_d;
    logic       tank_rst_q, tank_rst_d;
    logic       bk0_q, bk0_d;
    logic       bk1_q, bk1_d;
    logic [3:0] score0_q, score0_d;
    logic [3:0] score1_q, score1_d;
    logic [1:0] winner_q, winner_d;

    // hit1: P0's bullet on P1's tank; hit0: P1's bullet on P0's tank.
    // The evaluated hit merges the sticky accumulator with the current cycle,
    // so an overlap landing exactly on the fe cycle is not lost.
    logic       hit0, hit1;
    logic       win0, win1;
    logic [3:0] score0_inc, score1_inc;

`ifdef ROUND_TIMER_EN
    logic [10:0] tmr_q, tmr_d;
    logic        timed_out_q, timed_out_d;
    logic        to_set;
`endif

    always_comb begin
        frame_dly_d = frame_clk;
        fe_d        = frame_clk & ~frame_dly_q;

        hit1 = hit1_acc_q | (is_bullet0 & is_tank1);
        hit0 = hit0_acc_q | (is_bullet1 & is_tank0);

        score0_inc = (score0_q == 4'hF) ? 4'hF : score0_q + 4'd1;
        score1_inc = (score1_q == 4'hF) ? 4'hF : score1_q + 4'd1;

        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        tank_rst_d = 1'b0;
        bk0_d      = 1'b0;
        bk1_d      = 1'b0;
        score0_d   = score0_q;
        score1_d   = score1_q;
        winner_d   = winner_q;
        win0       = 1'b0;
        win1       = 1'b0;
`ifdef ROUND_TIMER_EN
        to_set     = 1'b0;
`endif

        // Accumulators only collect in PLAY. They drain on every fe so that
        // overlaps from HOLD never leak into the next round.
        hit0_acc_d = hit0_acc_q;
        hit1_acc_d = hit1_acc_q;
        if (fe_q) begin
            hit0_acc_d = 1'b0;
            hit1_acc_d = 1'b0;
        end else if (state_q == S_PLAY) begin
            hit0_acc_d = hit0;
            hit1_acc_d = hit1;
        end

        case (state_q)
            S_IDLE: begin
                if (fe_q && keycode == START_KEY) begin
                    state_d    = S_PLAY;
                    score0_d   = 4'd0;
                    score1_d   = 4'd0;
                    winner_d   = 2'b00;
                    tank_rst_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (fe_q) begin
                    if (hit0 || hit1) begin
                        if (hit1) begin
                            score0_d = score0_inc;
                            bk0_d    = 1'b1;
                        end
                        if (hit0) begin
                            score1_d = score1_inc;
                            bk1_d    = 1'b1;
                        end
                        win0 = hit1 && (score0_inc >= WIN_SCORE);
                        win1 = hit0 && (score1_inc >= WIN_SCORE);
                        if (win0 || win1) begin
                            state_d  = S_OVER;
                            winner_d = {win1, win0};
                        end else begin
                            state_d    = S_HOLD;
                            hold_cnt_d = HOLD_FRAMES;
                        end
                    end
`ifdef ROUND_TIMER_EN
                    // A hit in the same frame wins over the timeout.
                    else if (tmr_q == ROUND_FRAMES - 11'd1) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = HOLD_FRAMES;
                        to_set     = 1'b1;
                    end
`endif
                end
            end
            S_HOLD: begin
                // A count of 0 exits on the first fe, the same as 1.
                if (fe_q) begin
                    if (hold_cnt_q <= 8'd1) begin
                        state_d    = S_PLAY;
                        tank_rst_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                if (fe_q && keycode == START_KEY) state_d = S_IDLE;
            end
        endcase

        can_move_d = (state_d == S_PLAY);

`ifdef ROUND_TIMER_EN
        tmr_d = tmr_q;
        if (state_q != S_PLAY && state_d == S_PLAY) tmr_d = 11'd0;
        else if (state_q == S_PLAY && fe_q)         tmr_d = tmr_q + 11'd1;

        timed_out_d = timed_out_q;
        if (to_set)                                      timed_out_d = 1'b1;
        else if (state_q == S_HOLD && state_d != S_HOLD) timed_out_d = 1'b0;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            frame_dly_q <= 1'b0;
            fe_q        <= 1'b0;
            hit0_acc_q  <= 1'b0;
            hit1_acc_q  <= 1'b0;
            hold_cnt_q  <= 8'd0;
            can_move_q  <= 1'b0;
            tank_rst_q  <= 1'b0;
            bk0_q       <= 1'b0;
            bk1_q       <= 1'b0;
            score0_q    <= 4'd0;
            score1_q    <= 4'd0;
            winner_q    <= 2'b00;
`ifdef ROUND_TIMER_EN
            tmr_q       <= 11'd0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            frame_dly_q <= frame_dly_d;
            fe_q        <= fe_d;
            hit0_acc_q  <= hit0_acc_d;
            hit1_acc_q  <= hit1_acc_d;
            hold_cnt_q  <= hold_cnt_d;
            can_move_q  <= can_move_d;
            tank_rst_q  <= tank_rst_d;
            bk0_q       <= bk0_d;
            bk1_q       <= bk1_d;
            score0_q    <= score0_d;
            score1_q    <= score1_d;
            winner_q    <= winner_d;
`ifdef ROUND_TIMER_EN
            tmr_q       <= tmr_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

`ifdef ROUND_TIMER_EN
    assign timed_out = timed_out_q;
`else
    // ROUND_FRAMES only feeds the round timer; keep it referenced.
    logic unused_round_frames;
    assign unused_round_frames = ^ROUND_FRAMES;
    assign timed_out = 1'b0;
`endif

    assign state        = state_q;
    assign can_move     = can_move_q;
    assign tank_rst     = tank_rst_q;
    assign bullet_kill0 = bk0_q;
    assign bullet_kill1 = bk1_q;
    assign score0       = score0_q;
    assign score1       = score1_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
module tb_game_round_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       is_tank0 = 1'b0, is_bullet0 = 1'b0, is_tank1 = 1'b0, is_bullet1 = 1'b0;
    logic       can_move, tank_rst, bullet_kill0, bullet_kill1, timed_out;
    logic [3:0] score0, score1;
    logic [1:0] winner, state;

    int n_tests = 0;
    int n_fail  = 0;

    game_round_ctrl #(
        .WIN_SCORE   (4'd5),
        .HOLD_FRAMES (8'd60),
        .START_KEY   (8'h29),
        .ROUND_FRAMES(11'd4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .is_tank0    (is_tank0),
        .is_bullet0  (is_bullet0),
        .is_tank1    (is_tank1),
        .is_bullet1  (is_bullet1),
        .can_move    (can_move),
        .tank_rst    (tank_rst),
        .bullet_kill0(bullet_kill0),
        .bullet_kill1(bullet_kill1),
        .score0      (score0),
        .score1      (score1),
        .winner      (winner),
        .state       (state),
        .timed_out   (timed_out)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One frame_clk rise; returns one cycle after the fe cycle, when the
    // registered outputs already reflect that frame.
    task automatic frame();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    task automatic hit_p0();
        is_bullet0 = 1'b1; is_tank1 = 1'b1;
        step();
        is_bullet0 = 1'b0; is_tank1 = 1'b0;
        step();
    endtask

    task automatic hit_p1();
        is_bullet1 = 1'b1; is_tank0 = 1'b1;
        step();
        is_bullet1 = 1'b0; is_tank0 = 1'b0;
        step();
    endtask

    task automatic hit_both();
        is_bullet0 = 1'b1; is_tank1 = 1'b1; is_bullet1 = 1'b1; is_tank0 = 1'b1;
        step();
        is_bullet0 = 1'b0; is_tank1 = 1'b0; is_bullet1 = 1'b0; is_tank0 = 1'b0;
        step();
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, {state, can_move, tank_rst, bullet_kill0, bullet_kill1,
                  score0, score1, winner, timed_out}, 32'd0);
    endtask

    // 60 frames in HOLD, the last one returns to PLAY with a tank_rst pulse.
    task automatic hold_out(input string tag);
        frames(59);
        chk({tag, " still hold"}, state, 2'b10);
        frame();
        chk({tag, " back to play"}, state, 2'b01);
        chk({tag, " tank_rst"}, tank_rst, 1'b1);
        step();
        chk({tag, " tank_rst end"}, tank_rst, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        Reset = 1'b0;
        chk_reset("reset values");

        // No start key -> stay idle.
        frame();
        chk("idle no key", state, 2'b00);

        // Start: outputs change one cycle after the fe cycle.
        keycode = 8'h29;
        frame_clk = 1'b1;
        step();
        chk("start latency", state, 2'b00);
        frame_clk = 1'b0;
        step();
        keycode = 8'h00;
        chk("start state", state, 2'b01);
        chk("start tank_rst", tank_rst, 1'b1);
        chk("start can_move", can_move, 1'b1);
        chk("start scores", {score0, score1, winner}, 10'd0);
        step();
        chk("start tank_rst width", tank_rst, 1'b0);

        // P0 hits P1 mid-frame, picked up by the accumulator.
        hit_p0();
        frame();
        chk("hit p0 score0", score0, 4'd1);
        chk("hit p0 score1", score1, 4'd0);
        chk("hit p0 kills", {bullet_kill0, bullet_kill1}, 2'b10);
        chk("hit p0 state", state, 2'b10);
        chk("hit p0 can_move", can_move, 1'b0);
        step();
        chk("hit p0 kill width", bullet_kill0, 1'b0);

        // Overlaps in HOLD are ignored, including one just before exit.
        hit_p1();
        frames(59);
        chk("hold overlap state", state, 2'b10);
        hit_p1();
        frame();
        chk("hold exit state", state, 2'b01);
        chk("hold exit tank_rst", tank_rst, 1'b1);
        chk("hold overlap score1", score1, 4'd0);
        frame();
        chk("acc empty state", state, 2'b01);
        chk("acc empty scores", {score0, score1}, 8'h10);

        // P1 hits P0 exactly on the fe cycle (current-cycle overlap path).
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        is_bullet1 = 1'b1; is_tank0 = 1'b1;
        step();
        is_bullet1 = 1'b0; is_tank0 = 1'b0;
        chk("fe hit score1", score1, 4'd1);
        chk("fe hit kills", {bullet_kill0, bullet_kill1}, 2'b01);
        chk("fe hit state", state, 2'b10);
        hold_out("g1 r2");

        // Both hit in the same frame, up to 4/4.
        for (int s = 2; s <= 4; s++) begin
            hit_both();
            frame();
            chk("double scores", {score0, score1}, {s[3:0], s[3:0]});
            chk("double kills", {bullet_kill0, bullet_kill1}, 2'b11);
            chk("double state", state, 2'b10);
            hold_out("double");
        end

        // 4/4 -> 5/5: draw.
        hit_both();
        frame();
        chk("draw scores", {score0, score1}, 8'h55);
        chk("draw winner", winner, 2'b11);
        chk("draw state", state, 2'b11);
        chk("draw can_move", can_move, 1'b0);

        // OVER is frozen without the start key.
        hit_both();
        frame();
        chk("over frozen", {state, score0, score1, winner}, {2'b11, 8'h55, 2'b11});

        // Restart: OVER -> IDLE -> PLAY with cleared scores.
        keycode = 8'h29;
        frame();
        chk("over to idle", state, 2'b00);
        frame();
        keycode = 8'h00;
        chk("restart state", state, 2'b01);
        chk("restart clear", {score0, score1, winner}, 10'd0);

        // Reach HOLD with score0=3, then reset together with fe and a hit.
        for (int s = 1; s <= 2; s++) begin
            hit_p0();
            frame();
            hold_out("g2");
        end
        hit_p0();
        frame();
        chk("g2 score0 3", {state, score0}, {2'b10, 4'd3});
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        Reset = 1'b1;
        is_bullet0 = 1'b1; is_tank1 = 1'b1;
        step();
        chk_reset("mid-game reset");
        Reset = 1'b0;
        is_bullet0 = 1'b0; is_tank1 = 1'b0;
        step();
        chk_reset("after reset");

        // Game 3: P0 wins alone.
        keycode = 8'h29;
        frame();
        keycode = 8'h00;
        chk("g3 start", state, 2'b01);
        for (int s = 1; s <= 4; s++) begin
            hit_p0();
            frame();
            hold_out("g3");
        end
        hit_p0();
        frame();
        chk("p0 win scores", {score0, score1}, 8'h50);
        chk("p0 win winner", winner, 2'b01);
        chk("p0 win state", {state, can_move}, {2'b11, 1'b0});

        // Round timer: 4 PLAY frames without a hit.
        keycode = 8'h29;
        frame();
        frame();
        keycode = 8'h00;
        chk("g4 start", state, 2'b01);
        frames(3);
        chk("timer 3 frames", state, 2'b01);
        frame();
`ifdef ROUND_TIMER_EN
        chk("timeout state", state, 2'b10);
        chk("timeout flag", timed_out, 1'b1);
        chk("timeout scores", {score0, score1, bullet_kill0, bullet_kill1}, 10'd0);
        frames(59);
        chk("timeout held", timed_out, 1'b1);
        frame();
        chk("timeout exit", {state, timed_out}, {2'b01, 1'b0});
`else
        chk("no timer state", state, 2'b01);
        chk("no timer flag", timed_out, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
